// File: rtl/mult_share_if.sv
// Request/grant/result bundle between two requesters and the shared sequential multiplier.
// Handshake: reqN is held (with aN/bN stable) until gntN pulses; the operands are taken on that
// edge. done pulses once per grant with res/done_id, which stay put until the next done.
interface mult_share_if #(parameter int WIDTH = 8);
  logic               req0;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic               req1;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic               gnt0;
  logic               gnt1;
  logic               busy;
  logic               done;
  logic               done_id;
  logic [2*WIDTH-1:0] res;
  logic [1:0]         state_dbg;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, res, state_dbg
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, res, state_dbg
  );
endinterface

// File: rtl/mult_share_seq.sv
// Shift-add WIDTHxWIDTH multiplier shared round-robin between two requesters; one partial
// product per cycle, result returned with a one-cycle done pulse.
module mult_share_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input logic          CLOCK_50,
  input logic          reset,
  mult_share_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 id;
  logic                 last_id;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   pp;
  logic [CNT_W-1:0]     cnt;
  logic                 grant0;
  logic                 grant1;
  logic                 busy_r;
  logic                 done_r;
  logic                 done_id_r;
  logic [2*WIDTH-1:0]   res_r;

  // Grants are combinational so the requester sees the pulse in the capture cycle itself.
  // On contention the side that did not win last time goes first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.req0 && (!bus.req1 || last_id))
        grant0 = 1'b1;
      else if (bus.req1)
        grant1 = 1'b1;
    end
  end

  always_comb begin
    pp       = op_b[cnt] ? ({{WIDTH{1'b0}}, op_a} << cnt) : '0;
    acc_next = acc + pp;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      id        <= 1'b0;
      last_id   <= 1'b1;
      acc       <= '0;
      cnt       <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      done_id_r <= 1'b0;
      res_r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (grant0 || grant1) begin
            op_a    <= grant0 ? bus.a0 : bus.a1;
            op_b    <= grant0 ? bus.b0 : bus.b1;
            id      <= grant1;
            last_id <= grant1;
            acc     <= '0;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          // Last bit: publish the result so done/res are valid throughout DONE.
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state     <= DONE;
            done_r    <= 1'b1;
            res_r     <= acc_next;
            done_id_r <= id;
          end
        end
        DONE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt0      = grant0;
  assign bus.gnt1      = grant1;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.done_id   = done_id_r;
  assign bus.res       = res_r;
  assign bus.state_dbg = state;

endmodule
